// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int          INSTR_W          = 16;
  localparam logic [3:0]  HALT_OPCODE_DFLT = 4'hF;
  localparam logic [15:0] NOP              = 16'h0000;

  typedef enum logic [2:0] {
    FETCH = 3'd0,
    WAIT  = 3'd1,
    HOLD  = 3'd2,
    DROP  = 3'd3,
    HALT  = 3'd4
  } fetch_state_e;

  function automatic logic [INSTR_W-1:0] pc_inc2(input logic [INSTR_W-1:0] pc);
    return pc + 16'd2;
  endfunction

  function automatic logic is_halt(input logic [INSTR_W-1:0] instr, input logic [3:0] opcode);
    return (instr[15:12] == opcode);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bundle between fetch and imem.
interface fetch_unit_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rdy;
  logic [15:0] imem_data;

  modport master (output imem_req, output imem_addr, input imem_rdy, input imem_data);
  modport slave  (input imem_req, input imem_addr, output imem_rdy, output imem_data);
endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry parking slot for a fetched word that decode could not take yet.
module fetch_skid_buf
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               unload,
  input  logic               flush,
  input  logic [INSTR_W-1:0] d_instr,
  input  logic [INSTR_W-1:0] d_pc_plus2,
  output logic               valid,
  output logic [INSTR_W-1:0] instr,
  output logic [INSTR_W-1:0] pc_plus2
);

  // Entry state; flush beats load, load beats unload.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid    <= 1'b0;
      instr    <= NOP;
      pc_plus2 <= 16'h0000;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid    <= 1'b1;
      instr    <= d_instr;
      pc_plus2 <= d_pc_plus2;
    end else if (unload) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: imem handshake FSM, next-PC mux and IF/ID register.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [3:0]  HALT_OPCODE = HALT_OPCODE_DFLT
)
(
  input  logic                clk,
  input  logic                rst,
  input  logic [INSTR_W-1:0]  pc_cur,
  output logic [INSTR_W-1:0]  pc_next,
  output logic                pc_wen,
  fetch_unit_if.master        imem,
  input  logic                id_stall,
  input  logic                br_taken,
  input  logic [INSTR_W-1:0]  br_target,
  output logic                if_valid,
  output logic [INSTR_W-1:0]  if_instr,
  output logic [INSTR_W-1:0]  if_pc_plus2,
  output logic                halted
);

  fetch_state_e       state_r, state_s;
  logic [INSTR_W-1:0] req_addr_r;
  logic [INSTR_W-1:0] cur_addr_s;
  logic               accept_s;
  logic               ifid_free_s;
  logic               halt_word_s;
  logic               skid_valid_s;
  logic [INSTR_W-1:0] skid_instr_s;
  logic [INSTR_W-1:0] skid_pc_plus2_s;

  assign cur_addr_s  = (state_r == FETCH) ? pc_cur : req_addr_r;
  assign ifid_free_s = !if_valid || !id_stall;
  assign halt_word_s = is_halt(imem.imem_data, HALT_OPCODE);

  fetch_skid_buf u_skid (
    .clk        (clk),
    .rst        (rst),
    .load       (accept_s && !ifid_free_s),
    .unload     (skid_valid_s && ifid_free_s && !br_taken),
    .flush      (br_taken),
    .d_instr    (imem.imem_data),
    .d_pc_plus2 (pc_inc2(cur_addr_s)),
    .valid      (skid_valid_s),
    .instr      (skid_instr_s),
    .pc_plus2   (skid_pc_plus2_s)
  );

  // Next state, imem request and PC-register controls.
  always_comb begin
    state_s        = state_r;
    pc_wen         = 1'b0;
    pc_next        = pc_cur;
    accept_s       = 1'b0;
    imem.imem_req  = 1'b0;
    imem.imem_addr = req_addr_r;
    if (!rst) begin
      pc_wen  = 1'b1;
      pc_next = RESET_PC;
      state_s = FETCH;
    end else begin
      case (state_r)
        FETCH, WAIT: begin
          imem.imem_req  = 1'b1;
          imem.imem_addr = cur_addr_s;
        end
        DROP:    imem.imem_req = 1'b1;
        default: imem.imem_req = 1'b0;
      endcase
      if (br_taken) begin
        pc_wen  = 1'b1;
        pc_next = br_target;
        // An outstanding request must still be drained before a new address goes out.
        state_s = (!imem.imem_rdy && (state_r == WAIT || state_r == DROP)) ? DROP : FETCH;
      end else begin
        case (state_r)
          FETCH, WAIT: begin
            if (imem.imem_rdy) begin
              accept_s = 1'b1;
              pc_next  = pc_inc2(cur_addr_s);
              pc_wen   = !halt_word_s;
              if (halt_word_s) begin
                state_s = HALT;
              end else if (ifid_free_s) begin
                state_s = FETCH;
              end else begin
                state_s = HOLD;
              end
            end else begin
              state_s = WAIT;
            end
          end
          HOLD: begin
            if (ifid_free_s) begin
              state_s = FETCH;
            end else begin
              state_s = HOLD;
            end
          end
          DROP: begin
            if (imem.imem_rdy) begin
              state_s = FETCH;
            end else begin
              state_s = DROP;
            end
          end
          HALT:    state_s = HALT;
          default: state_s = FETCH;
        endcase
      end
    end
  end

  // FSM state, latched request address and HALT flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= FETCH;
      req_addr_r <= 16'h0000;
      halted     <= 1'b0;
    end else begin
      state_r    <= state_s;
      req_addr_r <= cur_addr_s;
      halted     <= (state_s == HALT);
    end
  end

  // IF/ID register: fresh word first, then the parked word; held while decode stalls.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if_valid    <= 1'b0;
      if_instr    <= NOP;
      if_pc_plus2 <= 16'h0000;
    end else if (br_taken) begin
      if_valid <= 1'b0;
    end else if (accept_s && ifid_free_s) begin
      if_valid    <= 1'b1;
      if_instr    <= imem.imem_data;
      if_pc_plus2 <= pc_inc2(cur_addr_s);
    end else if (skid_valid_s && ifid_free_s) begin
      if_valid    <= 1'b1;
      if_instr    <= skid_instr_s;
      if_pc_plus2 <= skid_pc_plus2_s;
    end else if (!id_stall) begin
      if_valid <= 1'b0;
    end
  end

endmodule
